// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/forwarding controller.
//   - forward-select encodings driven onto ForwardA/ForwardB
//   - interrupt-entry FSM state encoding
//   - default register-address width
package pipeline_hazard_ctrl_pkg;

  localparam int AW_DEF = 5;

  localparam logic [1:0] FWD_BUS   = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PEND    = 2'd1,
    TAKE    = 2'd2,
    SERVICE = 2'd3
  } irq_state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_sel_unit.sv
// Forward-select decision for one EX operand (pure combinational).
// Ports:
//   src       in  AW  source register read by the ID instruction
//   use_src   in  1   the ID instruction really reads src
//   alu_src   in  1   operand comes from shamt/immediate, never forwarded
//   ex_wr     in  1   EX shadow writes a register
//   ex_rd     in  AW  EX shadow destination
//   mem_wr    in  1   MEM shadow writes a register
//   mem_rd    in  AW  MEM shadow destination
//   sel       out 2   FWD_BUS / FWD_MEMWB / FWD_EXMEM
module fwd_sel_unit
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int AW = AW_DEF
)(
  input  logic [AW-1:0] src,
  input  logic          use_src,
  input  logic          alu_src,
  input  logic          ex_wr,
  input  logic [AW-1:0] ex_rd,
  input  logic          mem_wr,
  input  logic [AW-1:0] mem_rd,
  output logic [1:0]    sel
);

  // The younger result (EX) shadows the older one (MEM).
  always_comb begin
    sel = FWD_BUS;
    if (use_src && !alu_src) begin
      if (ex_wr && (ex_rd != '0) && (ex_rd == src))
        sel = FWD_EXMEM;
      else if (mem_wr && (mem_rd != '0) && (mem_rd == src))
        sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage pipeline.
// Tracks destination info of the instructions in EX and MEM, registers the
// EX operand forward selects, generates the load-use stall, branch flush and
// sequences interrupt entry.
// Ports:
//   clk, reset                      clock / async active-high reset
//   ID_rs, ID_rt, ID_use_rs/rt      ID source registers and their use bits
//   ID_ALUSrc1/2                    ID operand A is shamt / B is immediate
//   ID_rd, ID_RegWr, ID_MemRead     ID destination info
//   EX_BrTaken                      branch resolved taken in EX
//   irq, eret                       interrupt request / return pulse
//   ForwardA/B                      registered EX operand selects
//   PC_stall, IFID_stall            hold PC and IF/ID
//   IFID_flush, IDEX_bubble         zero IF/ID, insert NOP into ID/EX
//   irq_take, irq_busy              handler redirect pulse / in service
//
// Interrupt FSM:
//   state   | meaning
//   IDLE    | no request
//   PEND    | request seen, waiting for a cycle with no stall and no branch
//   TAKE    | one cycle: redirect PC, flush IF/ID, bubble ID/EX
//   SERVICE | handler running, irq ignored until eret
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int LU_STALL = 1
)(
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] ID_rs,
  input  logic [AW-1:0] ID_rt,
  input  logic          ID_use_rs,
  input  logic          ID_use_rt,
  input  logic          ID_ALUSrc1,
  input  logic          ID_ALUSrc2,
  input  logic [AW-1:0] ID_rd,
  input  logic          ID_RegWr,
  input  logic          ID_MemRead,
  input  logic          EX_BrTaken,
  input  logic          irq,
  input  logic          eret,
  output logic [1:0]    ForwardA,
  output logic [1:0]    ForwardB,
  output logic          PC_stall,
  output logic          IFID_stall,
  output logic          IFID_flush,
  output logic          IDEX_bubble,
  output logic          irq_take,
  output logic          irq_busy
);

  localparam int CW = 2;

  // Only EX and MEM destinations feed a select; a WB copy would be dead logic.
  logic          ex_wr, ex_ld, mem_wr;
  logic [AW-1:0] ex_rd, mem_rd;
  logic [CW-1:0] stall_cnt;
  logic [1:0]    fwd_a_nxt, fwd_b_nxt;
  logic          lu_trig, stall_busy, flush, stall, bubble;
  irq_state_t    state, state_nxt;

  fwd_sel_unit #(.AW(AW)) u_fwd_a (
    .src(ID_rs), .use_src(ID_use_rs), .alu_src(ID_ALUSrc1),
    .ex_wr(ex_wr), .ex_rd(ex_rd), .mem_wr(mem_wr), .mem_rd(mem_rd),
    .sel(fwd_a_nxt)
  );

  fwd_sel_unit #(.AW(AW)) u_fwd_b (
    .src(ID_rt), .use_src(ID_use_rt), .alu_src(ID_ALUSrc2),
    .ex_wr(ex_wr), .ex_rd(ex_rd), .mem_wr(mem_wr), .mem_rd(mem_rd),
    .sel(fwd_b_nxt)
  );

  assign lu_trig = ex_ld && (ex_rd != '0) &&
                   ((ID_use_rs && (ex_rd == ID_rs)) || (ID_use_rt && (ex_rd == ID_rt)));
  assign stall_busy = lu_trig || (stall_cnt != '0);

  // A taken branch or interrupt entry kills the ID instruction, so any
  // pending load-use stall belongs to the wrong path and is dropped.
  assign flush  = EX_BrTaken || (state == TAKE);
  assign stall  = stall_busy && !flush;
  assign bubble = stall || flush;

  assign PC_stall    = stall;
  assign IFID_stall  = stall;
  assign IFID_flush  = flush;
  assign IDEX_bubble = bubble;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_wr  <= 1'b0;
      ex_ld  <= 1'b0;
      ex_rd  <= '0;
      mem_wr <= 1'b0;
      mem_rd <= '0;
    end else begin
      mem_wr <= ex_wr;
      mem_rd <= ex_rd;
      if (bubble) begin
        ex_wr <= 1'b0;
        ex_ld <= 1'b0;
        ex_rd <= '0;
      end else begin
        ex_wr <= ID_RegWr;
        ex_ld <= ID_MemRead;
        ex_rd <= ID_rd;
      end
    end
  end

  // A stall always bubbles ID/EX, so holding the selects while stalled is
  // subsumed by loading FWD_BUS for the NOP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ForwardA <= FWD_BUS;
      ForwardB <= FWD_BUS;
    end else if (bubble) begin
      ForwardA <= FWD_BUS;
      ForwardB <= FWD_BUS;
    end else begin
      ForwardA <= fwd_a_nxt;
      ForwardB <= fwd_b_nxt;
    end
  end

  // The trigger cycle is itself the first stall cycle, so the counter only
  // covers the remaining LU_STALL-1 cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_cnt <= '0;
    else if (flush)
      stall_cnt <= '0;
    else if (lu_trig)
      stall_cnt <= CW'(LU_STALL - 1);
    else if (stall_cnt != '0)
      stall_cnt <= stall_cnt - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    irq_take  = 1'b0;
    irq_busy  = 1'b0;
    case (state)
      IDLE: begin
        if (irq) state_nxt = PEND;
      end
      PEND: begin
        if (!irq)
          state_nxt = IDLE;
        else if (!stall_busy && !EX_BrTaken)
          state_nxt = TAKE;
      end
      TAKE: begin
        irq_take  = 1'b1;
        state_nxt = SERVICE;
      end
      SERVICE: begin
        irq_busy = 1'b1;
        if (eret) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances (LU_STALL=1 and 3) share one
// directed stimulus; a cycle-level model predicts every output of both.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] id_rs, id_rt, id_rd;
  logic id_use_rs, id_use_rt, id_alu1, id_alu2, id_regwr, id_memrd;
  logic br, irq, eret;

  logic [1:0][1:0] fa, fb;
  logic [1:0] pcs, ifs, ifl, bub, tk, bsy;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.AW(5), .LU_STALL(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .ID_rs(id_rs), .ID_rt(id_rt), .ID_use_rs(id_use_rs), .ID_use_rt(id_use_rt),
    .ID_ALUSrc1(id_alu1), .ID_ALUSrc2(id_alu2), .ID_rd(id_rd),
    .ID_RegWr(id_regwr), .ID_MemRead(id_memrd), .EX_BrTaken(br),
    .irq(irq), .eret(eret),
    .ForwardA(fa[0]), .ForwardB(fb[0]), .PC_stall(pcs[0]), .IFID_stall(ifs[0]),
    .IFID_flush(ifl[0]), .IDEX_bubble(bub[0]), .irq_take(tk[0]), .irq_busy(bsy[0])
  );

  pipeline_hazard_ctrl #(.AW(5), .LU_STALL(3)) u_dut3 (
    .clk(clk), .reset(reset),
    .ID_rs(id_rs), .ID_rt(id_rt), .ID_use_rs(id_use_rs), .ID_use_rt(id_use_rt),
    .ID_ALUSrc1(id_alu1), .ID_ALUSrc2(id_alu2), .ID_rd(id_rd),
    .ID_RegWr(id_regwr), .ID_MemRead(id_memrd), .EX_BrTaken(br),
    .irq(irq), .eret(eret),
    .ForwardA(fa[1]), .ForwardB(fb[1]), .PC_stall(pcs[1]), .IFID_stall(ifs[1]),
    .IFID_flush(ifl[1]), .IDEX_bubble(bub[1]), .irq_take(tk[1]), .irq_busy(bsy[1])
  );

  // ---------------- model ----------------
  typedef struct packed {logic wr; logic ld; logic [4:0] rd;} rec_t;

  rec_t       m_ex[2], m_mem[2];
  logic [1:0] m_fa[2], m_fb[2];
  int         m_stall_end[2];   // last cycle index covered by a load-use stall
  bit         m_pend[2], m_take[2], m_serv[2];
  int         cyc;

  function automatic int lu_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic bit m_hazard(input int k);
    return m_ex[k].ld && (m_ex[k].rd != 0) &&
           ((id_use_rs && m_ex[k].rd == id_rs) || (id_use_rt && m_ex[k].rd == id_rt));
  endfunction

  function automatic bit m_in_stall(input int k);
    return m_hazard(k) || (cyc <= m_stall_end[k]);
  endfunction

  function automatic bit m_flush(input int k);
    return br || m_take[k];
  endfunction

  function automatic bit m_stalled(input int k);
    return !m_flush(k) && m_in_stall(k);
  endfunction

  function automatic logic [1:0] m_fwd(input int k, input logic [4:0] src, input bit u, input bit alu);
    if (!u || alu) return 2'd0;
    if (m_ex[k].wr && m_ex[k].rd != 0 && m_ex[k].rd == src) return 2'd2;
    if (m_mem[k].wr && m_mem[k].rd != 0 && m_mem[k].rd == src) return 2'd1;
    return 2'd0;
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        cyc = 0;
        for (int k = 0; k < 2; k++) begin
          m_ex[k] = '0; m_mem[k] = '0; m_fa[k] = 2'd0; m_fb[k] = 2'd0;
          m_stall_end[k] = -1; m_pend[k] = 0; m_take[k] = 0; m_serv[k] = 0;
        end
      end else begin
        for (int k = 0; k < 2; k++) begin
          bit hz, busy, fl, st;
          hz = m_hazard(k); busy = m_in_stall(k); fl = m_flush(k); st = m_stalled(k);
          if (fl || st) begin
            m_fa[k] = 2'd0; m_fb[k] = 2'd0;
          end else begin
            m_fa[k] = m_fwd(k, id_rs, id_use_rs, id_alu1);
            m_fb[k] = m_fwd(k, id_rt, id_use_rt, id_alu2);
          end
          if (m_serv[k]) begin
            if (eret) m_serv[k] = 0;
          end else if (m_take[k]) begin
            m_take[k] = 0; m_serv[k] = 1;
          end else if (m_pend[k]) begin
            if (!irq) m_pend[k] = 0;
            else if (!busy && !br) begin m_pend[k] = 0; m_take[k] = 1; end
          end else if (irq) begin
            m_pend[k] = 1;
          end
          if (fl) m_stall_end[k] = -1;
          else if (hz) m_stall_end[k] = cyc + lu_of(k) - 1;
          m_mem[k] = m_ex[k];
          m_ex[k] = (fl || st) ? rec_t'('0) : {id_regwr, id_memrd, id_rd};
        end
        cyc++;
      end
    end
  end

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (LU_STALL=%0d) got %0d expected %0d at %0t", nm, lu_of(k), act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        bit fl, st;
        fl = m_flush(k); st = m_stalled(k);
        chk("ForwardA", k, fa[k], m_fa[k]);
        chk("ForwardB", k, fb[k], m_fb[k]);
        chk("PC_stall", k, pcs[k], st);
        chk("IFID_stall", k, ifs[k], st);
        chk("IFID_flush", k, ifl[k], fl);
        chk("IDEX_bubble", k, bub[k], fl || st);
        chk("irq_take", k, tk[k], m_take[k]);
        chk("irq_busy", k, bsy[k], m_serv[k]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic id_set(input int d, s, t, input bit w, l, us, ut, a1, a2);
    id_rd = 5'(d); id_rs = 5'(s); id_rt = 5'(t);
    id_regwr = w; id_memrd = l; id_use_rs = us; id_use_rt = ut;
    id_alu1 = a1; id_alu2 = a2;
  endtask

  task automatic alu(input int d, s, t);
    id_set(d, s, t, 1, 0, 1, 1, 0, 0);
  endtask

  task automatic ld(input int d, s);
    id_set(d, s, 0, 1, 1, 1, 0, 0, 0);
  endtask

  task automatic nop();
    id_set(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; br = 0; irq = 0; eret = 0; nop();
    tick; settle;
    for (int k = 0; k < 2; k++) begin
      chk("rst_ForwardA", k, fa[k], 0);
      chk("rst_PC_stall", k, pcs[k], 0);
      chk("rst_irq_busy", k, bsy[k], 0);
    end
    reset = 1'b0;

    // back-to-back dependency
    tick; alu(3, 1, 2);
    tick; alu(4, 3, 3);
    tick; nop(); settle;
    for (int k = 0; k < 2; k++) begin chk("b2b_A", k, fa[k], 2); chk("b2b_B", k, fb[k], 2); end

    // one gap
    tick; alu(3, 1, 2);
    tick; nop();
    tick; alu(4, 3, 3);
    tick; nop(); settle;
    for (int k = 0; k < 2; k++) begin chk("gap_A", k, fa[k], 1); chk("gap_B", k, fb[k], 1); end

    // $0 destination
    tick; alu(0, 1, 2);
    tick; alu(4, 0, 0);
    tick; nop(); settle;
    for (int k = 0; k < 2; k++) begin chk("r0_A", k, fa[k], 0); chk("r0_B", k, fb[k], 0); end

    // EXMEM priority, unused rt
    tick; alu(5, 1, 2);
    tick; alu(5, 1, 2);
    tick; id_set(9, 5, 5, 1, 0, 1, 0, 0, 0);
    tick; nop(); settle;
    for (int k = 0; k < 2; k++) begin chk("prio_A", k, fa[k], 2); chk("unused_B", k, fb[k], 0); end

    // sll: shamt operand must not be forwarded
    tick; alu(5, 1, 2);
    tick; id_set(6, 5, 5, 1, 0, 1, 1, 1, 0);
    tick; nop(); settle;
    for (int k = 0; k < 2; k++) begin chk("sll_A", k, fa[k], 0); chk("sll_B", k, fb[k], 2); end

    // load-use
    tick; nop();
    tick; ld(2, 1);
    tick; alu(7, 2, 1); settle;
    for (int k = 0; k < 2; k++) begin
      chk("lu_pcs", k, pcs[k], 1); chk("lu_ifs", k, ifs[k], 1); chk("lu_bub", k, bub[k], 1);
    end
    tick; settle; chk("lu_c2_pcs", 0, pcs[0], 0); chk("lu_c2_pcs", 1, pcs[1], 1);
    tick; settle; chk("lu_fwdA", 0, fa[0], 1); chk("lu_c3_pcs", 1, pcs[1], 1);
    tick; settle; chk("lu_c4_pcs", 1, pcs[1], 0);
    tick; nop();

    // load-use cancelled by taken branch
    tick; ld(2, 1);
    tick; alu(7, 2, 1); br = 1; settle;
    for (int k = 0; k < 2; k++) begin
      chk("br_pcs", k, pcs[k], 0); chk("br_flush", k, ifl[k], 1); chk("br_bub", k, bub[k], 1);
    end
    tick; nop(); br = 0; settle;
    for (int k = 0; k < 2; k++) chk("br_after_pcs", k, pcs[k], 0);

    // irq during load-use stall
    tick; ld(2, 1);
    tick; alu(7, 2, 1); irq = 1;
    tick; settle; chk("irq_c1_take", 0, tk[0], 0); chk("irq_c1_take", 1, tk[1], 0);
    tick; settle; chk("irq_c2_take", 0, tk[0], 1); chk("irq_c2_take", 1, tk[1], 0);
    tick; settle; chk("irq_c3_take", 0, tk[0], 0); chk("irq_c3_busy", 0, bsy[0], 1);
    chk("irq_c3_take", 1, tk[1], 0);
    tick; nop(); settle; chk("irq_c4_take", 1, tk[1], 1);
    tick; settle; chk("irq_c5_busy", 1, bsy[1], 1);
    tick; irq = 0;
    tick; irq = 1;
    tick; irq = 0; eret = 1; settle;
    for (int k = 0; k < 2; k++) begin chk("svc_busy", k, bsy[k], 1); chk("svc_take", k, tk[k], 0); end
    tick; eret = 0; settle;
    for (int k = 0; k < 2; k++) chk("eret_busy", k, bsy[k], 0);

    // eret outside SERVICE, irq dropped in PEND
    tick; eret = 1;
    tick; eret = 0;
    tick; ld(2, 1);
    tick; alu(7, 2, 1); irq = 1;
    tick; irq = 0;
    tick; nop();
    repeat (3) tick;
    settle;
    for (int k = 0; k < 2; k++) chk("drop_busy", k, bsy[k], 0);

    // PEND waits for branch, then reset mid-SERVICE
    tick; irq = 1;
    tick; br = 1;
    tick; br = 0; settle;
    for (int k = 0; k < 2; k++) chk("pend_br_take", k, tk[k], 0);
    tick; settle;
    for (int k = 0; k < 2; k++) chk("pend_take", k, tk[k], 1);
    tick; settle;
    for (int k = 0; k < 2; k++) chk("svc2_busy", k, bsy[k], 1);
    reset = 1; settle;
    for (int k = 0; k < 2; k++) begin chk("rst_svc_busy", k, bsy[k], 0); chk("rst_svc_take", k, tk[k], 0); end
    tick; irq = 0;
    tick; reset = 0;
    repeat (3) tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
